// File: rtl/bpsk_pkg.sv
// Shared types and default constants for the BPSK symbol serializer.
package bpsk_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      PREAMBLE = 2'd2
   } state_t;

   localparam int N_HAMMING = 7;
   localparam int N_BCH     = 15;
   localparam int SPS_DEF   = 4;
   localparam int AMP_DEF   = 64;

endpackage

// File: rtl/bpsk_sym_timer.sv
// Sample / bit counters for the serializer. Provides current-position strobes
// and a look-ahead strobe telling whether the next position is a word's last sample.
module bpsk_sym_timer #(
   parameter int SPS     = 4,
   parameter int N       = 7,
   parameter int PRE_LEN = 8,
   parameter int NB      = 7
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_pre,
   output logic o_samp_last,
   output logic o_bit_last,
   output logic o_word_last,
   output logic o_word_end_nxt
);

   localparam int SW = (SPS > 1) ? $clog2(SPS) : 1;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;

   logic [SW-1:0] r_samp, w_samp_nxt;
   logic [BW-1:0] r_bit, w_bit_nxt;
   logic [BW-1:0] w_bit_lim;

   // Preamble and payload run different bit counts through the same counter
   assign w_bit_lim   = i_pre ? BW'(PRE_LEN - 1) : BW'(N - 1);
   // With SPS=1 every cycle is the last sample of its bit
   assign o_samp_last = (SPS == 1) ? 1'b1 : (r_samp == SW'(SPS - 1));
   assign o_bit_last  = (r_bit == w_bit_lim);
   assign o_word_last = o_samp_last && o_bit_last;

   // Counter advance: sample counter wraps into the bit counter
   always_comb begin
      w_samp_nxt = r_samp;
      w_bit_nxt  = r_bit;
      if (i_clr) begin
         w_samp_nxt = '0;
         w_bit_nxt  = '0;
      end else if (i_en) begin
         if (o_samp_last) begin
            w_samp_nxt = '0;
            w_bit_nxt  = o_bit_last ? '0 : r_bit + BW'(1);
         end else begin
            w_samp_nxt = r_samp + SW'(1);
         end
      end
   end

   // Look-ahead lets the top register LastSym in step with the sample it marks
   assign o_word_end_nxt = ((SPS == 1) || (w_samp_nxt == SW'(SPS - 1))) &&
                           (w_bit_nxt == BW'(N - 1));

   // Counter registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_samp <= '0;
         r_bit  <= '0;
      end else begin
         r_samp <= w_samp_nxt;
         r_bit  <= w_bit_nxt;
      end
   end

endmodule

// File: rtl/bpsk_symbol_serializer.sv
// BPSK symbol serializer: one N-bit codeword per handshake, sent MSB-first as
// +/-AMP samples, each bit held SPS clocks. Optional alternating preamble ahead
// of words started from idle is enabled with BPSK_SER_PREAMBLE_EN.
module bpsk_symbol_serializer
   import bpsk_pkg::*;
#(
   parameter int N       = N_HAMMING,
   parameter int SPS     = SPS_DEF,
   parameter int AMP_W   = 8,
   parameter int AMP     = AMP_DEF,
   parameter int PRE_LEN = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N-1:0]     DataIn,
   input  logic             InValid,
   output logic             InReady,
   output logic [AMP_W-1:0] SymOut,
   output logic             SymValid,
   output logic             BitOut,
   output logic             LastSym
);

`ifdef BPSK_SER_PREAMBLE_EN
   localparam int NB = (PRE_LEN > N) ? PRE_LEN : N;
`else
   localparam int NB = N;
`endif

   localparam logic signed [AMP_W-1:0] P_POS = AMP_W'(AMP);
   localparam logic signed [AMP_W-1:0] P_NEG = -P_POS;

   state_t         r_state, w_state_nxt;
   logic [N-1:0]   r_sr, w_sr_nxt;
   logic           w_acc, w_bit_nxt;
   logic           w_tmr_clr, w_tmr_en;
   logic           w_samp_last, w_bit_last, w_word_last, w_word_end_nxt;
   logic           r_symvalid, r_bitout, r_last;
   logic [AMP_W-1:0] r_sym;
`ifdef BPSK_SER_PREAMBLE_EN
   logic           r_pre, w_pre_nxt;
`endif

   bpsk_sym_timer #(.SPS(SPS), .N(N), .PRE_LEN(PRE_LEN), .NB(NB)) u_tmr (
      .i_clk          (CLK),
      .i_rst          (RST),
      .i_clr          (w_tmr_clr),
      .i_en           (w_tmr_en),
      .i_pre          (r_state == PREAMBLE),
      .o_samp_last    (w_samp_last),
      .o_bit_last     (w_bit_last),
      .o_word_last    (w_word_last),
      .o_word_end_nxt (w_word_end_nxt)
   );

   assign InReady = !RST && ((r_state == IDLE) || ((r_state == SHIFT) && w_word_last));
   assign w_acc   = InValid && InReady;

   // Next state, shift register and counter control
   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_tmr_clr   = 1'b0;
      w_tmr_en    = 1'b0;
`ifdef BPSK_SER_PREAMBLE_EN
      w_pre_nxt   = r_pre;
`endif
      if (RST) begin
         w_state_nxt = IDLE;
         w_sr_nxt    = '0;
         w_tmr_clr   = 1'b1;
`ifdef BPSK_SER_PREAMBLE_EN
         w_pre_nxt   = 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_acc) begin
                  w_sr_nxt  = DataIn;
                  w_tmr_clr = 1'b1;
`ifdef BPSK_SER_PREAMBLE_EN
                  w_state_nxt = PREAMBLE;
                  w_pre_nxt   = 1'b1;
`else
                  w_state_nxt = SHIFT;
`endif
               end
            end
            SHIFT: begin
               w_tmr_en = 1'b1;
               if (w_samp_last) begin
                  if (w_bit_last) begin
                     // Counters wrap to zero on their own, so a reload needs no gap
                     if (w_acc) w_sr_nxt    = DataIn;
                     else       w_state_nxt = IDLE;
                  end else begin
                     w_sr_nxt = r_sr << 1;
                  end
               end
            end
`ifdef BPSK_SER_PREAMBLE_EN
            PREAMBLE: begin
               w_tmr_en = 1'b1;
               if (w_samp_last) w_pre_nxt = ~r_pre;
               if (w_word_last) w_state_nxt = SHIFT;
            end
`endif
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Bit presented on the next sample
   always_comb begin
      w_bit_nxt = 1'b0;
      if (w_state_nxt == SHIFT) w_bit_nxt = w_sr_nxt[N-1];
`ifdef BPSK_SER_PREAMBLE_EN
      else if (w_state_nxt == PREAMBLE) w_bit_nxt = w_pre_nxt;
`endif
   end

   // State and data registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_sr    <= '0;
`ifdef BPSK_SER_PREAMBLE_EN
         r_pre   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
`ifdef BPSK_SER_PREAMBLE_EN
         r_pre   <= w_pre_nxt;
`endif
      end
   end

   // Registered sample outputs, computed from next-state values
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_symvalid <= 1'b0;
         r_bitout   <= 1'b0;
         r_sym      <= '0;
         r_last     <= 1'b0;
      end else begin
         r_symvalid <= (w_state_nxt != IDLE);
         r_bitout   <= w_bit_nxt;
         r_sym      <= (w_state_nxt == IDLE) ? '0 : (w_bit_nxt ? P_POS : P_NEG);
         r_last     <= (w_state_nxt == SHIFT) && w_word_end_nxt;
      end
   end

   assign SymValid = r_symvalid;
   assign SymOut   = r_sym;
   assign BitOut   = r_bitout;
   assign LastSym  = r_last;

endmodule

// File: tb/tb_bpsk_symbol_serializer.sv
// Directed bench for bpsk_symbol_serializer: N=7/SPS=4 instance plus an
// N=15/SPS=1 instance sharing clock and reset.
module tb_bpsk_symbol_serializer;

   localparam logic [7:0] P = 8'h40;
   localparam logic [7:0] M = 8'hC0;

   logic        CLK = 1'b0;
   logic        RST;
   logic [6:0]  din;
   logic        vin;
   logic        rdy, sv, bo, ls;
   logic [7:0]  so;
   logic [14:0] din1;
   logic        vin1;
   logic        rdy1, sv1, bo1, ls1;
   logic [7:0]  so1;
   logic [6:0]  w;
   logic [7:0]  e;

   int n_asrt = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   bpsk_symbol_serializer #(.N(7), .SPS(4), .AMP_W(8), .AMP(64), .PRE_LEN(8)) u0 (
      .CLK(CLK), .RST(RST), .DataIn(din), .InValid(vin), .InReady(rdy),
      .SymOut(so), .SymValid(sv), .BitOut(bo), .LastSym(ls)
   );

   bpsk_symbol_serializer #(.N(15), .SPS(1), .AMP_W(8), .AMP(64), .PRE_LEN(8)) u1 (
      .CLK(CLK), .RST(RST), .DataIn(din1), .InValid(vin1), .InReady(rdy1),
      .SymOut(so1), .SymValid(sv1), .BitOut(bo1), .LastSym(ls1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; vin = 1'b1; din = 7'h55; vin1 = 1'b0; din1 = '0;

      // reset held with a pending word: nothing accepted, outputs quiet
      repeat (3) begin
         tick();
         chk("rst_rdy", rdy, 0);
         chk("rst_sv", sv, 0);
         chk("rst_so", so, 0);
      end
      RST = 1'b0; vin = 1'b0;
      #1;
      chk("rst_rdy_after", rdy, 1);
      chk("rst_rdy1_after", rdy1, 1);

`ifndef BPSK_SER_PREAMBLE_EN
      // single word 1010011
      w = 7'b1010011;
      din = w; vin = 1'b1;
      #1;
      chk("sw_rdy", rdy, 1);
      tick();
      vin = 1'b0;
      for (int i = 0; i < 28; i++) begin
         e = w[6 - i/4] ? P : M;
         chk("sw_sv", sv, 1);
         chk("sw_so", so, e);
         chk("sw_bo", bo, w[6 - i/4]);
         chk("sw_ls", ls, (i == 27));
         if (i == 0)  chk("sw_busy_rdy", rdy, 0);
         if (i == 27) chk("sw_last_rdy", rdy, 1);
         if (i < 27) tick();
      end
      tick();
      chk("sw_idle_sv", sv, 0);
      chk("sw_idle_so", so, 0);
      chk("sw_idle_rdy", rdy, 1);
      chk("sw_idle_ls", ls, 0);

      // back-to-back 7F then 00; 00 is on DataIn while busy and must not leak in early
      din = 7'h7F; vin = 1'b1;
      #1;
      tick();
      din = 7'h00;
      for (int i = 0; i < 56; i++) begin
         chk("b2b_sv", sv, 1);
         chk("b2b_so", so, (i < 28) ? P : M);
         chk("b2b_ls", ls, (i == 27) || (i == 55));
         if (i == 27) chk("b2b_rdy", rdy, 1);
         if (i == 28) vin = 1'b0;
         if (i < 55) tick();
      end
      tick();
      chk("b2b_idle_sv", sv, 0);

      // mid-word reset with a simultaneous offered word
      din = 7'h7F; vin = 1'b1;
      #1;
      tick();
      vin = 1'b0;
      repeat (9) tick();
      chk("mr_sv_pre", sv, 1);
      chk("mr_so_pre", so, P);
      RST = 1'b1; vin = 1'b1;
      #1;
      chk("mr_rdy_in_rst", rdy, 0);
      tick();
      RST = 1'b0; vin = 1'b0;
      #1;
      chk("mr_sv", sv, 0);
      chk("mr_so", so, 0);
      chk("mr_rdy", rdy, 1);
      din = 7'h00; vin = 1'b1;
      #1;
      tick();
      vin = 1'b0;
      chk("mr_new_sv", sv, 1);
      chk("mr_new_so", so, M);
      chk("mr_new_bo", bo, 0);
      repeat (27) tick();
      chk("mr_new_ls", ls, 1);
      tick();
      chk("mr_new_idle", sv, 0);

      // SPS=1, N=15
      din1 = 15'h4000; vin1 = 1'b1;
      #1;
      tick();
      vin1 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk("s1_sv", sv1, 1);
         chk("s1_so", so1, (i == 0) ? P : M);
         chk("s1_ls", ls1, (i == 14));
         if (i < 14) tick();
      end
      tick();
      chk("s1_idle_sv", sv1, 0);
      chk("s1_idle_rdy", rdy1, 1);
`else
      // preamble: 7F from idle gets 8 alternating bits, then 00 back-to-back gets none
      din = 7'h7F; vin = 1'b1;
      #1;
      tick();
      din = 7'h00;
      for (int i = 0; i < 88; i++) begin
         if (i < 32)      e = (((i/4) % 2) == 0) ? P : M;
         else if (i < 60) e = P;
         else             e = M;
         chk("pre_sv", sv, 1);
         chk("pre_so", so, e);
         chk("pre_ls", ls, (i == 59) || (i == 87));
         if (i < 32)  chk("pre_rdy", rdy, 0);
         if (i == 59) chk("pre_last_rdy", rdy, 1);
         if (i == 60) vin = 1'b0;
         if (i < 87) tick();
      end
      tick();
      chk("pre_idle_sv", sv, 0);
      chk("pre_idle_rdy", rdy, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
